// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
//
// Single-port framebuffer arbiter shared by the VGA pixel path and the CPU.
// Framebuffer pixels are prefetched in raster order into a small show-ahead
// FIFO. The display pops that FIFO one pixel per active pixel clock. Memory
// slots the fetch does not need are granted to CPU reads and writes. At most
// one RAM access is issued per cycle.
//
// Ports (all synchronous to clk_25):
//   clk_25       pixel clock, the only clock
//   rst          synchronous active-high reset
//   frame_start  one-cycle pulse; flushes the FIFO and restarts fetch at 0
//   pix_pop      display consumes the FIFO head this cycle
//   pix_rgb      FIFO head pixel, 0 when empty
//   pix_valid    FIFO non-empty
//   underflow    sticky: pop seen while empty; cleared by frame_start / rst
//   cpu_req      CPU request, held until cpu_ack
//   cpu_we       1 = write, 0 = read
//   cpu_addr     CPU pixel address
//   cpu_wdata    CPU write pixel
//   cpu_ack      one-cycle completion pulse
//   cpu_rdata    read data, valid with cpu_ack
//   mem_en       registered RAM strobe
//   mem_we       registered RAM write enable
//   mem_addr     registered RAM address
//   mem_wdata    registered RAM write data
//   mem_rdata    synchronous RAM read data, one cycle after mem_en
// ---------------------------------------------------------------------------
module fb_arbiter #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FB_PIXELS  = 307200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOW_WATER  = 8
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [8:0]        pix_rgb,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [8:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [8:0]        cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [8:0]        mem_wdata,
    input  logic [8:0]        mem_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    // One extra bit so level + inflight can never wrap.
    localparam int unsigned SUM_W = LVL_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);
    localparam logic [SUM_W-1:0]  DEPTH_S   = SUM_W'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0]  LOW_S     = SUM_W'(LOW_WATER);

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_RD1,
        CPU_RD2,
        CPU_COOL
    } cpu_state_t;

    cpu_state_t cpu_state;
    cpu_state_t cpu_state_nxt;

    // Prefetch FIFO storage and bookkeeping
    logic [8:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    // Fetch sequencing
    logic              fetch_active;
    logic [ADDR_W-1:0] fetch_addr;
    // fetch_p1: fetch issued at the previous edge (RAM reading now)
    // fetch_p2: fetch whose data is on mem_rdata this cycle
    logic              fetch_p1;
    logic              fetch_p2;
    logic [SUM_W-1:0]  occupancy;

    // Arbitration / control
    logic              cpu_idle;
    logic              rd_capture;
    logic              cpu_ok;
    logic              fetch_ok;
    logic              grant_fetch;
    logic              grant_cpu;
    logic              fifo_push;
    logic              fifo_pop;
    logic              pop_empty;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    always_comb begin
        occupancy   = SUM_W'(level) + SUM_W'(fetch_p1) + SUM_W'(fetch_p2);
        cpu_ok      = cpu_req && cpu_idle;
        // No fetch on a frame_start edge: the address is being rewound.
        fetch_ok    = fetch_active && !frame_start && (occupancy < DEPTH_S);
        grant_fetch = fetch_ok && ((occupancy < LOW_S) || !cpu_ok);
        grant_cpu   = cpu_ok && !grant_fetch;
    end

    // -----------------------------------------------------------------------
    // FIFO control
    // frame_start flushes the FIFO, drops the returning fetch and ignores a
    // coincident pop.
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_push = fetch_p2 && !frame_start;
        fifo_pop  = pix_pop && (level != '0) && !frame_start;
        pop_empty = pix_pop && (level == '0) && !frame_start;
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            level        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            underflow    <= 1'b0;
            fetch_active <= 1'b0;
            fetch_addr   <= '0;
            fetch_p1     <= 1'b0;
            fetch_p2     <= 1'b0;
        end else begin
            fetch_p1 <= grant_fetch;
            // Clearing the pipeline tag discards the stale return.
            fetch_p2 <= fetch_p1 && !frame_start;

            if (frame_start) begin
                level        <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                underflow    <= 1'b0;
                fetch_active <= 1'b1;
                fetch_addr   <= '0;
            end else begin
                if (grant_fetch) begin
                    // Stop after the last pixel; the address never wraps here.
                    if (fetch_addr == LAST_ADDR) begin
                        fetch_active <= 1'b0;
                    end else begin
                        fetch_addr <= fetch_addr + 1'b1;
                    end
                end

                if (fifo_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (pop_empty) begin
                    underflow <= 1'b1;
                end

                case ({fifo_push, fifo_pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst && fifo_push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_comb begin
        pix_valid = (level != '0);
        pix_rgb   = pix_valid ? fifo_mem[rd_ptr] : '0;
    end

    // -----------------------------------------------------------------------
    // CPU FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25) begin
        if (rst) begin
            cpu_state <= CPU_IDLE;
        end else begin
            cpu_state <= cpu_state_nxt;
        end
    end

    // CPU FSM: next state
    always_comb begin
        cpu_state_nxt = cpu_state;
        case (cpu_state)
            CPU_IDLE: begin
                if (grant_cpu) begin
                    cpu_state_nxt = cpu_we ? CPU_COOL : CPU_RD1;
                end
            end
            CPU_RD1:  cpu_state_nxt = CPU_RD2;
            CPU_RD2:  cpu_state_nxt = CPU_COOL;
            // One dead edge so a request still held after ack is not regranted.
            CPU_COOL: cpu_state_nxt = CPU_IDLE;
            default:  cpu_state_nxt = CPU_IDLE;
        endcase
    end

    // CPU FSM: outputs
    always_comb begin
        cpu_idle   = (cpu_state == CPU_IDLE);
        rd_capture = (cpu_state == CPU_RD2);
    end

    // -----------------------------------------------------------------------
    // RAM port and CPU response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            mem_en <= grant_fetch || grant_cpu;
            mem_we <= grant_cpu && cpu_we;
            if (grant_fetch) begin
                mem_addr <= fetch_addr;
            end else if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end

            // Writes ack at the grant edge; reads ack when data is captured.
            cpu_ack <= (grant_cpu && cpu_we) || rd_capture;
            if (rd_capture) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

    // Shortened frame so that complete frames fit in a short run.
    localparam int unsigned TB_PIXELS = 100;

    logic        clk_25;
    logic        rst;
    logic        frame_start;
    logic        pix_pop;
    logic [8:0]  pix_rgb;
    logic        pix_valid;
    logic        underflow;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [8:0]  cpu_wdata;
    logic        cpu_ack;
    logic [8:0]  cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [8:0]  mem_wdata;
    logic [8:0]  mem_rdata;

    fb_arbiter #(
        .ADDR_W    (19),
        .FB_PIXELS (TB_PIXELS),
        .FIFO_DEPTH(16),
        .LOW_WATER (8)
    ) dut (
        .clk_25     (clk_25),
        .rst        (rst),
        .frame_start(frame_start),
        .pix_pop    (pix_pop),
        .pix_rgb    (pix_rgb),
        .pix_valid  (pix_valid),
        .underflow  (underflow),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [8:0]  wdata;
        logic [8:0]  rdata;
        int          lat;
    } cpu_vec_t;

    int          checks = 0;
    int          errors = 0;
    int          fetch_cnt = 0;
    int          ack_cnt = 0;
    logic [18:0] last_fetch = '0;
    int          fetch_base;
    int          ack_snap;
    int          wr_n;
    int          last_ack;
    bit          disp_done;
    bit          got;

    logic [8:0]  ram [0:4095];
    logic [8:0]  exp_pix [$];
    logic [18:0] wr_q [$];
    cpu_vec_t    cpu_sb [$];
    cpu_vec_t    vec [6];
    cpu_vec_t    sb_e;

    function automatic logic [8:0] pat(input int unsigned a);
        return 9'((a * 37 + 5) % 512);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_25);
        #1;
    endtask

    task automatic do_frame_start;
        exp_pix.delete();
        for (int i = 0; i < int'(TB_PIXELS); i++) exp_pix.push_back(pat(i));
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        fetch_base = fetch_cnt;
    endtask

    task automatic pop_frame(input int n);
        for (int p = 0; p < n; p++) begin
            check("pop_valid", pix_valid, 1);
            check("pop_pixel", pix_rgb, exp_pix.pop_front());
            pix_pop = 1'b1;
            tick;
        end
        pix_pop = 1'b0;
    endtask

    // Synchronous single-port RAM model
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = pat(i);
        forever begin
            @(posedge clk_25);
            if (mem_en) begin
                if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
                else        mem_rdata <= ram[mem_addr[11:0]];
            end
        end
    end

    // Fetch and ack monitor (display-region addresses are fetches)
    always @(negedge clk_25) begin
        if (mem_en && !mem_we && (mem_addr < 19'(TB_PIXELS))) begin
            fetch_cnt++;
            last_fetch = mem_addr;
        end
        if (cpu_ack) ack_cnt++;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_pop = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // ---- reset state
        tick; tick; tick;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_rgb", pix_rgb, 0);
        check("rst_underflow", underflow, 0);
        rst = 1'b0;
        tick; tick;
        check("idle_no_fetch", mem_en, 0);

        // ---- initial fill: addresses 0..15 back to back, then stall
        do_frame_start();
        check("fs_no_fetch", mem_en, 0);
        for (int k = 0; k < 16; k++) begin
            tick;
            check("fill_mem_en", mem_en, 1);
            check("fill_mem_addr", mem_addr, k);
            if (k == 1) check("fill_valid_early", pix_valid, 0);
            if (k == 2) begin
                check("fill_valid", pix_valid, 1);
                check("fill_head", pix_rgb, pat(0));
            end
        end
        tick; check("fill_stall", mem_en, 0);
        tick; check("fill_stall2", mem_en, 0);

        // ---- continuous pop with CPU writes held
        disp_done = 1'b0;
        fork
            begin
                pop_frame(TB_PIXELS);
                disp_done = 1'b1;
            end
            begin
                wr_n = 0;
                last_ack = -10;
                cpu_we = 1'b1; cpu_addr = 19'(2000); cpu_wdata = 9'(1);
                cpu_req = 1'b1;
                wr_q.push_back(cpu_addr);
                for (int cyc = 0; cyc < 3000 && cpu_req; cyc++) begin
                    tick;
                    if (cpu_ack) begin
                        check("wr_ack_gap", (cyc - last_ack) >= 2, 1);
                        check("wr_mem_we", mem_we, 1);
                        check("wr_mem_addr", mem_addr, wr_q.pop_front());
                        last_ack = cyc;
                        wr_n++;
                        if (disp_done || wr_n >= 64) begin
                            cpu_req = 1'b0;
                        end else begin
                            cpu_addr  = 19'(2000 + wr_n);
                            cpu_wdata = 9'(wr_n * 11 + 1);
                            wr_q.push_back(cpu_addr);
                        end
                    end
                end
                check("wr_all_acked", cpu_req, 0);
                cpu_req = 1'b0;
                check("wr_some_done", wr_n >= 2, 1);
            end
        join
        check("stream_no_underflow", underflow, 0);
        tick; tick; tick; tick;
        check("frame1_fetch_count", fetch_cnt - fetch_base, TB_PIXELS);
        check("frame1_last_addr", last_fetch, TB_PIXELS - 1);
        check("frame1_idle", mem_en, 0);

        // ---- CPU transaction table
        vec[0] = '{1'b1, 19'd1000, 9'h1A5, 9'h000, 1};
        vec[1] = '{1'b0, 19'd1000, 9'h000, 9'h1A5, 3};
        vec[2] = '{1'b1, 19'd1001, 9'h0F0, 9'h000, 1};
        vec[3] = '{1'b0, 19'd1001, 9'h000, 9'h0F0, 3};
        vec[4] = '{1'b0, 19'd1002, 9'h000, pat(1002), 3};
        vec[5] = '{1'b0, 19'd2000, 9'h000, 9'h001, 3};
        for (int i = 0; i < 6; i++) begin
            cpu_we = vec[i].we; cpu_addr = vec[i].addr; cpu_wdata = vec[i].wdata;
            cpu_req = 1'b1;
            cpu_sb.push_back(vec[i]);
            got = 1'b0;
            for (int c = 1; c <= 8 && !got; c++) begin
                tick;
                if (cpu_ack) begin
                    sb_e = cpu_sb.pop_front();
                    got = 1'b1;
                    check("cpu_ack_latency", c, sb_e.lat);
                    if (sb_e.we) begin
                        check("cpu_wr_mem_we", mem_we, 1);
                        check("cpu_wr_mem_addr", mem_addr, sb_e.addr);
                        check("cpu_wr_mem_wdata", mem_wdata, sb_e.wdata);
                    end else begin
                        check("cpu_rdata", cpu_rdata, sb_e.rdata);
                    end
                end
            end
            check("cpu_ack_seen", got, 1);
            if (!got) cpu_sb.delete();
            // request still held: cool-down edge must not regrant
            tick;
            check("cool_no_grant", mem_en, 0);
            check("ack_single_cycle", cpu_ack, 0);
            cpu_req = 1'b0;
            tick;
        end

        // ---- frame_start with 10 entries in FIFO and 2 fetches in flight
        do_frame_start();
        for (int k = 0; k < 12; k++) tick;
        check("preflush_valid", pix_valid, 1);
        check("preflush_head", pix_rgb, pat(0));
        pix_pop = 1'b1;
        cpu_we = 1'b1; cpu_addr = 19'd1500; cpu_wdata = 9'h055; cpu_req = 1'b1;
        do_frame_start();
        pix_pop = 1'b0;
        cpu_req = 1'b0;
        check("flush_empty", pix_valid, 0);
        check("flush_rgb_zero", pix_rgb, 0);
        check("flush_cpu_ack", cpu_ack, 1);
        check("flush_cpu_we", mem_we, 1);
        check("flush_cpu_addr", mem_addr, 1500);
        tick;
        check("refetch_en", mem_en, 1);
        check("refetch_addr0", mem_addr, 0);
        check("stale1_discard", pix_valid, 0);
        tick;
        check("stale2_discard", pix_valid, 0);
        tick;
        check("refill_valid", pix_valid, 1);
        check("refill_head", pix_rgb, pat(0));
        tick; tick; tick;
        pop_frame(TB_PIXELS);
        tick; tick; tick; tick; tick; tick;
        check("frame2_fetch_count", fetch_cnt - fetch_base, TB_PIXELS);
        check("frame2_last_addr", last_fetch, TB_PIXELS - 1);
        check("frame2_no_more_fetch", mem_en, 0);

        // ---- pop on empty FIFO
        pix_pop = 1'b1;
        tick;
        pix_pop = 1'b0;
        check("empty_pop_underflow", underflow, 1);
        check("empty_pop_rgb", pix_rgb, 0);
        check("empty_pop_valid", pix_valid, 0);
        tick; tick; tick; tick; tick;
        check("underflow_sticky", underflow, 1);
        check("empty_no_fetch", mem_en, 0);
        do_frame_start();
        check("underflow_cleared", underflow, 0);

        // ---- rst during a CPU read at RD1
        for (int k = 0; k < 20; k++) tick;
        cpu_we = 1'b0; cpu_addr = 19'd1000; cpu_req = 1'b1;
        tick;
        check("rdrst_grant_en", mem_en, 1);
        check("rdrst_grant_we", mem_we, 0);
        check("rdrst_grant_addr", mem_addr, 1000);
        rst = 1'b1;
        cpu_req = 1'b0;
        ack_snap = ack_cnt;
        tick;
        rst = 1'b0;
        check("rdrst_mem_en", mem_en, 0);
        check("rdrst_mem_addr", mem_addr, 0);
        check("rdrst_mem_wdata", mem_wdata, 0);
        check("rdrst_cpu_ack", cpu_ack, 0);
        check("rdrst_cpu_rdata", cpu_rdata, 0);
        check("rdrst_pix_valid", pix_valid, 0);
        check("rdrst_pix_rgb", pix_rgb, 0);
        check("rdrst_underflow", underflow, 0);
        tick; tick; tick; tick;
        check("rdrst_no_ack", ack_cnt - ack_snap, 0);
        check("rdrst_fetch_stopped", mem_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
